mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequences data-memory accesses for the single-issue MIPS core, using the decoder's Size, MemRead and MemWrite fields. For each load or store it:
- checks alignment;
- generates big-endian byte enables and lane-replicated store data;
- runs a req/ack handshake with the data memory;
- sign- or zero-extends load data.
It holds the pipeline with stall until the access retires.

Parameters:
TIMEOUT, 255, ack wait limit in cycles (used only with MEMCTRL_TIMEOUT_EN); counter width is clog2(TIMEOUT+1).

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  execute-stage access valid, sampled in IDLE only
mem_read  in  1  decoder MemRead
mem_write  in  1  decoder MemWrite
size  in  2  decoder Size: 00 word, 01 half, 10 byte, 11 illegal
unsigned_ld  in  1  opcode bit 2 (lbu/lhu = 1)
addr  in  32  effective byte address
wdata  in  32  store data, right-justified
stall  out  1  hold pipeline
done  out  1  one-cycle retire pulse
rdata_ext  out  32  extended load data, valid with done
addr_err  out  1  one-cycle pulse, misaligned or illegal request
bus_err  out  1  one-cycle pulse, ack timeout
dmem_req  out  1  memory request
dmem_we  out  1  write enable
dmem_be  out  4  byte enables, be[3] = bits 31:24 = byte offset 0
dmem_addr  out  32  word address {addr[31:2],2'b00}
dmem_wdata  out  32  byte/half replicated into all lanes
dmem_rdata  in  32  read data, valid with ack
dmem_ack  in  1  memory completion

Behaviour:
- Reset: all outputs 0; state IDLE; internal registers cleared.
- States are IDLE, ACCESS, DONE, ERR.
- Accepted request: start=1 in IDLE with mem_read^mem_write=1.
- start with neither read nor write: ignored; no outputs change.
- start with both read and write, size=11, half access with addr[0]=1, or word access with addr[1:0]!=0: go to ERR; no dmem_req is issued.
- Capture on the accept edge: addr, size, we, unsigned_ld, wdata.
- stall is combinational: high in the accept cycle, and high in ACCESS and ERR.
- stall is low in IDLE (no start) and in DONE.
- ACCESS:
  - dmem_req=1 registered; dmem_addr, dmem_we, dmem_be and dmem_wdata are held stable until ack.
  - ack=1 → DONE; load data is captured on that edge.
  - The earliest ack is the first ACCESS cycle, giving 3-cycle minimum accept-to-done latency: accept, ACCESS, DONE.
- DONE: done=1 and rdata_ext valid for exactly one cycle, then IDLE. start is not sampled in DONE.
- ERR: addr_err=1 for one cycle, then IDLE. done is not asserted.
- Byte enables:
  - word: 1111
  - half, offset 0: 1100; half, offset 2: 0011
  - byte: one-hot be[3-addr[1:0]]
- Store data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Load extraction: the lane selected by the offset is right-justified, then sign-extended if unsigned_ld=0, else zero-extended. Word loads pass through.
- dmem_ack outside ACCESS is ignored.
- Asynchronous reset mid-access drops dmem_req immediately; no done is issued.

Optional Feature:
- Macro MEMCTRL_TIMEOUT_EN.
- When defined: a counter clears on entering ACCESS and increments each ACCESS cycle without ack. When count reaches TIMEOUT: dmem_req drops, go to ERR2 (stall=1), then bus_err=1 for one cycle, then IDLE; done is not asserted. Ack in the same cycle that TIMEOUT is reached wins, giving normal completion.
- When undefined: no counter, no ERR2; bus_err is tied 0; ACCESS waits indefinitely.

Decomposition:
- Shared package mips_pkg: Size encodings (SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10), state enum.
- The same Size constants are used by the decoder.
- One sub-module, mem_lane_align: combinational byte-enable, store-replication and load-extract/extend logic, reused by the instruction-fetch path.

Test Plan:
- lb at addr 0x103, dmem_rdata=0x000000F0, ack first ACCESS cycle → dmem_be=0001, done on cycle 3, rdata_ext=0xFFFFFFF0. lbu with same inputs → 0x000000F0.
- sh at addr 0x202, wdata=0x0000ABCD, ack after 4 wait cycles → dmem_addr=0x200, dmem_be=0011, dmem_wdata=0xABCDABCD, we=1; stall high through the wait cycles; done once.
- lw at addr 0x105 → addr_err pulse, dmem_req never high, done=0. start with size=11 → addr_err.
- start held high with mem_read=1 across DONE → second access begins only after the return to IDLE; exactly two done pulses.
- rst_n low during ACCESS → dmem_req, stall and done all 0 immediately; IDLE after release.
- MEMCTRL_TIMEOUT_EN, TIMEOUT=8, no ack → bus_err on cycle 11 after accept; dmem_req low from cycle 10. Ack at count 8 → done, no bus_err.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: Size encodings shared by the decoder and the data-memory path,
// plus the state type of the data-memory access controller.
// Build option MEMCTRL_TIMEOUT_EN adds the ack-timeout state ST_ERR2.
package mips_pkg;

   localparam logic [1:0] SZ_WORD    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_BYTE    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCESS = 3'd1,
      ST_DONE   = 3'd2,
      ST_ERR    = 3'd3
`ifdef MEMCTRL_TIMEOUT_EN
      ,
      ST_ERR2   = 3'd4
`endif
   } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: purely combinational big-endian lane logic. It produces byte
// enables and replicated store data for a given size/offset, and extracts and
// extends the addressed lane of a loaded word. Also used by the fetch path.
module mem_lane_align
   import mips_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  offset_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  laneByte;
   logic [15:0] laneHalf;

   // Select the addressed byte and half-word; offset 0 is the most significant lane
   always_comb begin
      laneByte = rdata_i[31:24];
      case (offset_i)
         2'd0:    laneByte = rdata_i[31:24];
         2'd1:    laneByte = rdata_i[23:16];
         2'd2:    laneByte = rdata_i[15:8];
         default: laneByte = rdata_i[7:0];
      endcase
      laneHalf = offset_i[1] ? rdata_i[15:0] : rdata_i[31:16];
   end

   // Size-dependent enables, store replication and load extension; word passes straight through
   always_comb begin
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      rdata_o = rdata_i;
      case (size_i)
         SZ_BYTE: begin
            be_o    = 4'b1000 >> offset_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{laneByte[7] & ~unsigned_i}}, laneByte};
         end
         SZ_HALF: begin
            be_o    = offset_i[1] ? 4'b0011 : 4'b1100;
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {{16{laneHalf[15] & ~unsigned_i}}, laneHalf};
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one load or store at a time to the data memory
// with a req/ack handshake, stalling the pipeline until the access retires.
// Misaligned or illegal requests raise addr_err without touching memory.
// Build option MEMCTRL_TIMEOUT_EN: abandon the access after TIMEOUT unacked
// ACCESS cycles and report bus_err; otherwise ACCESS waits forever.
module mem_access_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  size,
   input  logic        unsigned_ld,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata_ext,
   output logic        addr_err,
   output logic        bus_err,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack
);

   mem_state_e  state_q, state_d;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [1:0]  size_q;
   logic        we_q, unsigned_q, req_q;
   logic        anyOp, badReq, accept, reject;
   logic [3:0]  laneBe;
   logic [31:0] laneWdata, laneRdata;

   assign anyOp  = mem_read | mem_write;
   assign badReq = (mem_read & mem_write) | (size == SZ_ILLEGAL)
                 | ((size == SZ_HALF) & addr[0])
                 | ((size == SZ_WORD) & (addr[1:0] != 2'b00));
   assign accept = (state_q == ST_IDLE) & start & anyOp & ~badReq;
   assign reject = (state_q == ST_IDLE) & start & anyOp & badReq;

   mem_lane_align u_lane (
      .size_i     (size_q),
      .offset_i   (addr_q[1:0]),
      .unsigned_i (unsigned_q),
      .wdata_i    (wdata_q),
      .rdata_i    (dmem_rdata),
      .be_o       (laneBe),
      .wdata_o    (laneWdata),
      .rdata_o    (laneRdata)
   );

`ifdef MEMCTRL_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   logic [CntW-1:0] cnt_q;
   logic            busErr_q;
   logic            timeoutHit;

   // An ack arriving in the same cycle as the limit still completes normally
   assign timeoutHit = (state_q == ST_ACCESS) & ~dmem_ack & (cnt_q == CntW'(TIMEOUT));

   // Count unacknowledged ACCESS cycles, restarting from zero on every accepted request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= '0;
      end else if ((state_q == ST_ACCESS) && !dmem_ack && (cnt_q != CntW'(TIMEOUT))) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // bus_err pulses in the cycle after the single ERR2 cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busErr_q <= 1'b0;
      end else begin
         busErr_q <= (state_q == ST_ERR2);
      end
   end

   assign bus_err = busErr_q;
`else
   assign bus_err = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and pipeline-facing status; start is only looked at in IDLE
   always_comb begin
      state_d  = state_q;
      stall    = 1'b0;
      done     = 1'b0;
      addr_err = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stall = start & anyOp;
            if (accept) begin
               state_d = ST_ACCESS;
            end else if (reject) begin
               state_d = ST_ERR;
            end
         end
         ST_ACCESS: begin
            stall = 1'b1;
            if (dmem_ack) begin
               state_d = ST_DONE;
            end
`ifdef MEMCTRL_TIMEOUT_EN
            else if (timeoutHit) begin
               state_d = ST_ERR2;
            end
`endif
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            stall    = 1'b1;
            addr_err = 1'b1;
            state_d  = ST_IDLE;
         end
`ifdef MEMCTRL_TIMEOUT_EN
         ST_ERR2: begin
            stall   = 1'b1;
            state_d = ST_IDLE;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Capture the request on the accept edge; drop req and latch extended load data when ACCESS ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         size_q     <= '0;
         we_q       <= 1'b0;
         unsigned_q <= 1'b0;
         req_q      <= 1'b0;
      end else if (accept) begin
         addr_q     <= addr;
         wdata_q    <= wdata;
         size_q     <= size;
         we_q       <= mem_write;
         unsigned_q <= unsigned_ld;
         req_q      <= 1'b1;
      end else if ((state_q == ST_ACCESS) && (state_d != ST_ACCESS)) begin
         req_q <= 1'b0;
         if (dmem_ack) begin
            rdata_q <= laneRdata;
         end
      end
   end

   assign dmem_req   = req_q;
   assign dmem_we    = req_q & we_q;
   assign dmem_be    = req_q ? laneBe : 4'b0000;
   assign dmem_addr  = req_q ? {addr_q[31:2], 2'b00} : 32'h0;
   assign dmem_wdata = req_q ? laneWdata : 32'h0;
   assign rdata_ext  = done ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl. The driver pushes
// expected memory requests and retire/error events into queues; a monitor on
// the falling edge pops and compares whenever the DUT presents them.
// Build option MEMCTRL_TIMEOUT_EN selects TIMEOUT=8 and timeout scenarios.
module tb_mem_access_ctrl;
   import mips_pkg::*;

`ifdef MEMCTRL_TIMEOUT_EN
   localparam int TO = 8;
   localparam int DLY_MAX = 12;
`else
   localparam int TO = 255;
   localparam int DLY_MAX = 5;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0, mem_read = 1'b0, mem_write = 1'b0, unsigned_ld = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] addr = 32'h0, wdata = 32'h0, dmem_rdata = 32'h0;
   logic        dmem_ack = 1'b0;
   logic        stall, done, addr_err, bus_err, dmem_req, dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] rdata_ext, dmem_addr, dmem_wdata;

   mem_access_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mem_read(mem_read), .mem_write(mem_write),
      .size(size), .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
      .stall(stall), .done(done), .rdata_ext(rdata_ext), .addr_err(addr_err), .bus_err(bus_err),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
   );

   always #5 clk = ~clk;

   int cycleCnt = 0;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      int          firstCyc;
      int          lastCyc;
   } req_t;

   typedef struct {
      int          kind;
      logic [31:0] rdata;
      int          cyc;
   } resp_t;

   req_t  expReqQ[$];
   resp_t expRespQ[$];
   int    compared = 0;
   int    mismatched = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
      end
   endtask

   // Reference model: kind -1 ignored, 0 access, 1 address error
   function automatic void modelAccess(input logic rd, input logic wr, input logic [1:0] sz,
                                       input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                       input logic [31:0] rdm, output int kind, output logic [3:0] be,
                                       output logic [31:0] wrep, output logic [31:0] ext);
      int n, off;
      longint unsigned mask, lane, mult;
      n = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 0;
      off = int'(a[1:0]);
      be = 4'b0000;
      wrep = 32'h0;
      ext = 32'h0;
      if (!rd && !wr) begin
         kind = -1;
         return;
      end
      if ((rd && wr) || n == 0 || (off % n) != 0) begin
         kind = 1;
         return;
      end
      kind = 0;
      for (int i = 0; i < 4; i++) be[3-i] = (i >= off) && (i < off + n);
      mask = (64'd1 << (8 * n)) - 64'd1;
      mult = (n == 4) ? 64'd1 : (n == 2) ? 64'h0001_0001 : 64'h0101_0101;
      wrep = 32'((64'(wd) & mask) * mult);
      lane = (64'(rdm) >> (8 * (4 - off - n))) & mask;
      if (!uns && lane[8*n-1]) lane = lane | ~mask;
      ext = lane[31:0];
   endfunction

   // Monitor: compare memory requests and retire/error pulses against the queues
   req_t  curReq;
   resp_t curResp;
   logic  reqActive = 1'b0;
   logic  reqBogus = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         reqActive = 1'b0;
      end else begin
         if (dmem_req && !reqActive) begin
            checkOutput("req_expected", 64'(dmem_req), 64'(expReqQ.size() != 0));
            reqActive = 1'b1;
            reqBogus = (expReqQ.size() == 0);
            if (!reqBogus) begin
               curReq = expReqQ.pop_front();
               checkOutput("req_first_cycle", 64'(cycleCnt), 64'(curReq.firstCyc));
            end
         end else if (!dmem_req) begin
            reqActive = 1'b0;
         end
         if (dmem_req && !reqBogus) begin
            checkOutput("req_held_too_long", 64'(cycleCnt > curReq.lastCyc), 64'd0);
            checkOutput("dmem_addr", 64'(dmem_addr), 64'(curReq.addr));
            checkOutput("dmem_be", 64'(dmem_be), 64'(curReq.be));
            checkOutput("dmem_we", 64'(dmem_we), 64'(curReq.we));
            if (curReq.we) checkOutput("dmem_wdata", 64'(dmem_wdata), 64'(curReq.wdata));
            checkOutput("stall_during_req", 64'(stall), 64'd1);
         end
         if (done || addr_err || bus_err) begin
            checkOutput("resp_expected", 64'(done | addr_err | bus_err), 64'(expRespQ.size() != 0));
            if (expRespQ.size() != 0) begin
               curResp = expRespQ.pop_front();
               checkOutput("resp_kind", 64'({done, addr_err, bus_err}),
                           (curResp.kind == 0) ? 64'd4 : (curResp.kind == 1) ? 64'd2 : 64'd1);
               checkOutput("resp_cycle", 64'(cycleCnt), 64'(curResp.cyc));
               if (curResp.kind == 0) begin
                  checkOutput("rdata_ext", 64'(rdata_ext), 64'(curResp.rdata));
                  checkOutput("stall_in_done", 64'(stall), 64'd0);
               end
               if (curResp.kind == 1) checkOutput("stall_in_err", 64'(stall), 64'd1);
            end
         end
      end
   end

   // Issue one request, push its expectations and play the memory side with the given ack delay
   task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdm,
                                input int d);
      int kind, k;
      logic [3:0] be;
      logic [31:0] wrep, ext;
      modelAccess(rd, wr, sz, uns, a, wd, rdm, kind, be, wrep, ext);
`ifdef MEMCTRL_TIMEOUT_EN
      if (kind == 0 && d > TO) kind = 2;
`endif
      @(posedge clk); #1;
      k = cycleCnt;
      start = 1'b1; mem_read = rd; mem_write = wr; size = sz; unsigned_ld = uns;
      addr = a; wdata = wd; dmem_ack = 1'b0;
      if (kind == 0) begin
         expReqQ.push_back('{{a[31:2], 2'b00}, be, wrep, wr, k + 1, k + 1 + d});
         expRespQ.push_back('{0, ext, k + d + 2});
      end else if (kind == 1) begin
         expRespQ.push_back('{1, 32'h0, k + 1});
      end
`ifdef MEMCTRL_TIMEOUT_EN
      else if (kind == 2) begin
         expReqQ.push_back('{{a[31:2], 2'b00}, be, wrep, wr, k + 1, k + 1 + TO});
         expRespQ.push_back('{2, 32'h0, k + TO + 3});
      end
`endif
      #1;
      if (kind == 0) checkOutput("stall_accept", 64'(stall), 64'd1);
      else if (kind == -1) checkOutput("stall_ignored", 64'(stall), 64'd0);
      @(posedge clk); #1;
      start = 1'b0;
      mem_read = 1'($urandom); mem_write = 1'($urandom); size = 2'($urandom);
      unsigned_ld = 1'($urandom); addr = $urandom; wdata = $urandom; dmem_rdata = $urandom;
      if (kind == 0) begin
         for (int i = 0; i < d; i++) begin
            @(posedge clk); #1;
            dmem_rdata = $urandom;
         end
         dmem_ack = 1'b1;
         dmem_rdata = rdm;
         @(posedge clk); #1;
         dmem_ack = 1'b0;
         dmem_rdata = $urandom;
      end
`ifdef MEMCTRL_TIMEOUT_EN
      else if (kind == 2) begin
         repeat (TO + 1) @(posedge clk);
         #1;
      end
`endif
      @(posedge clk); #1;
   endtask

   // Idle cycles with stray acks and junk read data that must be ignored
   task automatic idleGap(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         dmem_ack = 1'($urandom);
         dmem_rdata = $urandom;
      end
      dmem_ack = 1'b0;
   endtask

   int kHold, kindTmp;
   logic [3:0] beTmp;
   logic [31:0] wrepTmp, ext1, ext2, r1, r2;

   initial begin
      #1 rst_n = 1'b0;
      #20;
      checkOutput("reset_ctrl", 64'({stall, done, addr_err, bus_err, dmem_req, dmem_we, dmem_be}), 64'd0);
      checkOutput("reset_addr", 64'(dmem_addr), 64'd0);
      checkOutput("reset_wdata", 64'(dmem_wdata), 64'd0);
      checkOutput("reset_rdata_ext", 64'(rdata_ext), 64'd0);
      @(posedge clk); #2 rst_n = 1'b1;

      $display("[TB] directed accesses");
      applyStimulus(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h0000_0103, 32'h1234_5678, 32'h0000_00F0, 0);
      applyStimulus(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h0000_0103, 32'h1234_5678, 32'h0000_00F0, 0);
      applyStimulus(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 4);
      applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0105, 32'h0, 32'h0, 0);
      applyStimulus(1'b1, 1'b0, SZ_ILLEGAL, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 0);
      applyStimulus(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 0);
      applyStimulus(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 0);
      applyStimulus(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h0000_0300, 32'h0, 32'h8001_7FFF, 1);
      applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0304, 32'h0, 32'h8765_4321, 2);

      $display("[TB] start held high across DONE");
      r1 = $urandom; r2 = $urandom;
      modelAccess(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0400, 32'h0, r1, kindTmp, beTmp, wrepTmp, ext1);
      modelAccess(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0400, 32'h0, r2, kindTmp, beTmp, wrepTmp, ext2);
      @(posedge clk); #1;
      kHold = cycleCnt;
      start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = SZ_WORD; addr = 32'h0000_0400;
      expReqQ.push_back('{32'h0000_0400, 4'hF, 32'h0, 1'b0, kHold + 1, kHold + 1});
      expReqQ.push_back('{32'h0000_0400, 4'hF, 32'h0, 1'b0, kHold + 4, kHold + 4});
      expRespQ.push_back('{0, ext1, kHold + 2});
      expRespQ.push_back('{0, ext2, kHold + 5});
      @(posedge clk); #1; dmem_ack = 1'b1; dmem_rdata = r1;
      @(posedge clk); #1; dmem_ack = 1'b0; dmem_rdata = $urandom;
      @(posedge clk); #1;
      @(posedge clk); #1; dmem_ack = 1'b1; dmem_rdata = r2;
      @(posedge clk); #1; dmem_ack = 1'b0; start = 1'b0; mem_read = 1'b0;
      @(posedge clk); #1;

      $display("[TB] reset during ACCESS");
      @(posedge clk); #1;
      kHold = cycleCnt;
      start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = SZ_WORD; addr = 32'h0000_0500;
      expReqQ.push_back('{32'h0000_0500, 4'hF, 32'h0, 1'b0, kHold + 1, kHold + 100});
      @(posedge clk); #1; start = 1'b0; mem_read = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_req", 64'(dmem_req), 64'd0);
      checkOutput("rst_mid_stall", 64'(stall), 64'd0);
      checkOutput("rst_mid_done", 64'(done), 64'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      idleGap(3);
      applyStimulus(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h0000_0601, 32'h0000_005A, 32'h0, 1);

`ifdef MEMCTRL_TIMEOUT_EN
      $display("[TB] ack timeout");
      applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0700, 32'h0, 32'h1111_2222, 20);
      applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0704, 32'h0, 32'h3333_4444, TO);
`endif

      $display("[TB] randomized accesses");
      for (int t = 0; t < 150; t++) begin
         int sel;
         logic rd, wr;
         sel = $urandom_range(0, 9);
         rd = (sel == 1) || (sel >= 2 && sel <= 5);
         wr = (sel == 1) || (sel >= 6);
         applyStimulus(rd, wr, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                       $urandom_range(0, DLY_MAX));
         idleGap($urandom_range(0, 2));
      end

      repeat (5) @(posedge clk);
      #1;
      checkOutput("pending_requests", 64'(expReqQ.size()), 64'd0);
      checkOutput("pending_responses", 64'(expRespQ.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Absolute time bound in case the run stops making progress
   initial begin
      #1_000_000;
      mismatched++;
      $display("[TB] FAIL watchdog: actual timeout required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
